// File: rtl/alu_issue_sequencer_if.sv
// Request / ALU / response signal bundle for alu_issue_sequencer.
// master = the sequencer, slave = dispatch + ALU + response consumer.
interface alu_issue_sequencer_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic             req_cmp;
    logic [7:0]       req_rs;
    logic [7:0]       req_rt;
    logic [TAG_W-1:0] req_tag;

    logic             alu_enable;
    logic [2:0]       alu_core_state;
    logic [1:0]       alu_arith_mux;
    logic             alu_output_mux;
    logic [7:0]       alu_rs;
    logic [7:0]       alu_rt;
    logic [7:0]       alu_out;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_data;
    logic [2:0]       rsp_nzp;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    modport master (
        input  req_valid, req_op, req_cmp, req_rs, req_rt, req_tag, alu_out, rsp_ready,
        output req_ready, alu_enable, alu_core_state, alu_arith_mux, alu_output_mux,
               alu_rs, alu_rt, rsp_valid, rsp_data, rsp_nzp, rsp_tag, rsp_err
    );

    modport slave (
        output req_valid, req_op, req_cmp, req_rs, req_rt, req_tag, alu_out, rsp_ready,
        input  req_ready, alu_enable, alu_core_state, alu_arith_mux, alu_output_mux,
               alu_rs, alu_rt, rsp_valid, rsp_data, rsp_nzp, rsp_tag, rsp_err
    );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Issues one request at a time to the 8-bit ALU and returns its registered result.
// Optional macro ALU_DIV_ZERO_CHECK_EN: answer DIV-by-zero locally with data FF, err 1.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// EXEC  | ALU enabled for one cycle, core_state 101
// WAIT  | EXTRA_WAIT cycles for slow ALU variants, core_state 110
// CAPT  | ALU result registered, sampled into the response, core_state 110
// RESP  | response valid until rsp_ready
module alu_issue_sequencer #(
    parameter int TAG_W      = 4,
    parameter int EXTRA_WAIT = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    alu_issue_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT,
        S_CAPT,
        S_RESP
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(EXTRA_WAIT - 1);

    state_t           state_q, state_d;
    logic [1:0]       op_q;
    logic             cmp_q;
    logic [7:0]       rs_q, rt_q;
    logic [TAG_W-1:0] tag_q;
    logic [3:0]       wait_cnt_q;
    logic [7:0]       data_q;
    logic [2:0]       nzp_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic             accept;
    logic             div_zero;

    assign accept = bus.req_valid && (state_q == S_IDLE);

`ifdef ALU_DIV_ZERO_CHECK_EN
    logic err_q;
    assign div_zero    = (bus.req_op == 2'b11) && !bus.req_cmp && (bus.req_rt == 8'h00);
    assign bus.rsp_err = err_q;
`else
    assign div_zero    = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.alu_rs         = rs_q;
    assign bus.alu_rt         = rt_q;
    assign bus.alu_arith_mux  = op_q;
    assign bus.alu_output_mux = cmp_q;
    assign bus.rsp_data       = data_q;
    assign bus.rsp_nzp        = nzp_q;
    assign bus.rsp_tag        = rsp_tag_q;

    always_comb begin
        state_d            = state_q;
        bus.req_ready      = 1'b0;
        bus.rsp_valid      = 1'b0;
        bus.alu_enable     = 1'b0;
        bus.alu_core_state = 3'b000;
        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (accept) state_d = div_zero ? S_RESP : S_EXEC;
            end
            S_EXEC: begin
                bus.alu_enable     = 1'b1;
                bus.alu_core_state = 3'b101;
                state_d            = (EXTRA_WAIT == 0) ? S_CAPT : S_WAIT;
            end
            S_WAIT: begin
                bus.alu_core_state = 3'b110;
                if (wait_cnt_q == 4'd0) state_d = S_CAPT;
            end
            S_CAPT: begin
                bus.alu_core_state = 3'b110;
                state_d            = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            op_q       <= 2'b00;
            cmp_q      <= 1'b0;
            rs_q       <= 8'h00;
            rt_q       <= 8'h00;
            tag_q      <= '0;
            wait_cnt_q <= 4'd0;
            data_q     <= 8'h00;
            nzp_q      <= 3'b000;
            rsp_tag_q  <= '0;
`ifdef ALU_DIV_ZERO_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= bus.req_op;
                cmp_q <= bus.req_cmp;
                rs_q  <= bus.req_rs;
                rt_q  <= bus.req_rt;
                tag_q <= bus.req_tag;
            end
            if (state_q == S_EXEC)
                wait_cnt_q <= WAIT_LOAD;
            else if (state_q == S_WAIT)
                wait_cnt_q <= wait_cnt_q - 4'd1;
            if (state_q == S_CAPT) begin
                data_q    <= bus.alu_out;
                nzp_q     <= cmp_q ? bus.alu_out[2:0] : 3'b000;
                rsp_tag_q <= tag_q;
`ifdef ALU_DIV_ZERO_CHECK_EN
                err_q     <= 1'b0;
`endif
            end
`ifdef ALU_DIV_ZERO_CHECK_EN
            // Divide-by-zero never reaches the ALU; the response is formed at accept.
            if (accept && div_zero) begin
                data_q    <= 8'hFF;
                nzp_q     <= 3'b000;
                rsp_tag_q <= bus.req_tag;
                err_q     <= 1'b1;
            end
`endif
        end
    end
endmodule
